pulse_pn_tx: RTL and testbench

Transmit-side counterpart of the pulse CIR averager. It generates a burst of identical PN-modulated pulses (BPSK on I, Q=0), each exactly seq_len samples long and framed with tlast. Bursts contain num_pulses pulses separated by programmable idle gaps, so the receive averager sees aligned, repeatable pulses. It sits in a noc_block between the setting registers and the axi_wrapper s_axis_data port.

---
 rtl/pulse_pn_tx_pkg.sv | 35 +++
 rtl/pulse_pn_tx_if.sv | 13 +
 rtl/pulse_pn_tx_lfsr.sv | 39 +++
 rtl/pulse_pn_tx.sv | 169 ++++++++++++++++
 tb/tb_pulse_pn_tx.sv | 352 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pulse_pn_tx_pkg.sv
// Shared definitions for the PN pulse transmitter: FSM states, stream widths,
// setting-register addresses, readback indices and the BPSK sample mapping.
package pulse_pn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int AXIS_DATA_W = 32;
    localparam int SAMPLE_W    = 16;

    localparam logic [7:0] SR_TX_START   = 8'd128;
    localparam logic [7:0] SR_SEQ_LEN    = 8'd129;
    localparam logic [7:0] SR_NUM_PULSES = 8'd130;
    localparam logic [7:0] SR_GAP_LEN    = 8'd131;
    localparam logic [7:0] SR_AMPLITUDE  = 8'd132;
    localparam logic [7:0] SR_LFSR_POLY  = 8'd133;
    localparam logic [7:0] SR_LFSR_SEED  = 8'd134;

    localparam int RB_PULSE_CNT = 0;
    localparam int RB_BUSY      = 1;

    // A one chip maps to +amplitude, a zero chip to -amplitude with plain
    // 16-bit wrap (no saturation, so -32768 stays -32768).
    function automatic logic [SAMPLE_W-1:0] bpsk_map(input logic outBit,
                                                     input logic [SAMPLE_W-1:0] amp);
        logic [SAMPLE_W-1:0] neg;
        neg = {SAMPLE_W{1'b0}} - amp;
        return outBit ? amp : neg;
    endfunction

endpackage

// File: rtl/pulse_pn_tx_if.sv
// AXI-Stream sample port of the PN pulse transmitter.
interface pulse_pn_tx_if;
    import pulse_pn_pkg::*;

    logic [AXIS_DATA_W-1:0] o_tdata;
    logic                   o_tvalid;
    logic                   o_tlast;
    logic                   o_tready;

    modport master (output o_tdata, output o_tvalid, output o_tlast, input o_tready);
    modport slave  (input o_tdata, input o_tvalid, input o_tlast, output o_tready);

endinterface

// File: rtl/pulse_pn_tx_lfsr.sv
// Fibonacci-style PN generator: shifts right, feedback enters at the MSB,
// the chip is the LSB. Load has priority so a pulse can restart cleanly.
module pn_lfsr #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         step,
    input  logic [W-1:0] seed,
    input  logic [W-1:0] poly,
    output logic         out_bit
);

    logic [W-1:0] lfsr_q;
    logic [W-1:0] lfsr_d;

    // Next LFSR value: reload from seed, advance one chip, or hold.
    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = seed;
        end else if (step) begin
            lfsr_d = {^(lfsr_q & poly), lfsr_q[W-1:1]};
        end
    end

    // LFSR register; a non-zero reset value keeps it from locking up.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= W'(1);
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign out_bit = lfsr_q[0];

endmodule

// File: rtl/pulse_pn_tx.sv
// Burst generator of identical PN/BPSK pulses framed with tlast, separated
// by programmable idle gaps, for the pulse CIR averager on the receive side.
module pulse_pn_tx
    import pulse_pn_pkg::*;
#(
    parameter int LFSR_W = 10,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [15:0]       seq_len,
    input  logic [CNT_W-1:0]  num_pulses,
    input  logic [CNT_W-1:0]  gap_len,
    input  logic [15:0]       amplitude,
    input  logic [LFSR_W-1:0] lfsr_poly,
    input  logic [LFSR_W-1:0] lfsr_seed,
    pulse_pn_tx_if.master     axis,
    output logic              busy,
    output logic [CNT_W-1:0]  pulse_cnt,
    output logic              done
);

    state_t              state_q, state_d;
    logic [15:0]         idx_q, idx_d;
    logic [CNT_W-1:0]    gapCnt_q, gapCnt_d;
    logic [CNT_W-1:0]    pulseCnt_q, pulseCnt_d;
    logic                abortPend_q, abortPend_d;

    logic [15:0]         seqLen_q;
    logic [CNT_W-1:0]    numPulses_q;
    logic [CNT_W-1:0]    gapLen_q;
    logic [15:0]         amp_q;
    logic [LFSR_W-1:0]   poly_q;
    logic [LFSR_W-1:0]   seed_q;

    logic                accept;
    logic                handshake;
    logic                lastBeat;
    logic                lfsrLoad;
    logic                lfsrStep;
    logic                lfsrBit;
    logic [LFSR_W-1:0]   seedIn;
    logic [LFSR_W-1:0]   lfsrSeed;

    assign seedIn    = (lfsr_seed == '0) ? LFSR_W'(1) : lfsr_seed;
    assign accept    = (state_q == IDLE) && start && !abort &&
                       (seq_len != '0) && (num_pulses != '0);
    assign handshake = (state_q == PULSE) && axis.o_tready;
    assign lastBeat  = (idx_q == seqLen_q - 16'd1);

    // The first pulse must start on the cycle after start, so the LFSR is
    // loaded from the live (coerced) seed before the snapshot is visible.
    assign lfsrSeed  = accept ? seedIn : seed_q;

    pn_lfsr #(.W(LFSR_W)) u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .load    (lfsrLoad),
        .step    (lfsrStep),
        .seed    (lfsrSeed),
        .poly    (poly_q),
        .out_bit (lfsrBit)
    );

    // Burst sequencing: next state, sample index, gap timer and pulse count.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        gapCnt_d    = gapCnt_q;
        pulseCnt_d  = pulseCnt_q;
        abortPend_d = abortPend_q;
        lfsrLoad    = 1'b0;
        lfsrStep    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    pulseCnt_d  = '0;
                    idx_d       = '0;
                    abortPend_d = 1'b0;
                    lfsrLoad    = 1'b1;
                    state_d     = PULSE;
                end
            end
            PULSE: begin
                if (abort) begin
                    abortPend_d = 1'b1;
                end
                if (handshake) begin
                    if (lastBeat) begin
                        pulseCnt_d = pulseCnt_q + CNT_W'(1);
                        idx_d      = '0;
                        lfsrLoad   = 1'b1;
                        if ((pulseCnt_q + CNT_W'(1) == numPulses_q) || abortPend_q || abort) begin
                            state_d = DONE;
                        end else if (gapLen_q == '0) begin
                            state_d = PULSE;
                        end else begin
                            gapCnt_d = '0;
                            state_d  = GAP;
                        end
                    end else begin
                        idx_d    = idx_q + 16'd1;
                        lfsrStep = 1'b1;
                    end
                end
            end
            GAP: begin
                if (abort) begin
                    state_d = DONE;
                end else if (gapCnt_q == gapLen_q - CNT_W'(1)) begin
                    state_d = PULSE;
                end else begin
                    gapCnt_d = gapCnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                abortPend_d = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            gapCnt_q    <= '0;
            pulseCnt_q  <= '0;
            abortPend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            gapCnt_q    <= gapCnt_d;
            pulseCnt_q  <= pulseCnt_d;
            abortPend_q <= abortPend_d;
        end
    end

    // Configuration snapshot taken only when a burst is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            seqLen_q    <= '0;
            numPulses_q <= '0;
            gapLen_q    <= '0;
            amp_q       <= '0;
            poly_q      <= '0;
            seed_q      <= LFSR_W'(1);
        end else if (accept) begin
            seqLen_q    <= seq_len;
            numPulses_q <= num_pulses;
            gapLen_q    <= gap_len;
            amp_q       <= amplitude;
            poly_q      <= lfsr_poly;
            seed_q      <= seedIn;
        end
    end

    assign axis.o_tvalid = (state_q == PULSE);
    assign axis.o_tlast  = (state_q == PULSE) && lastBeat;
    assign axis.o_tdata  = (state_q == PULSE) ? {bpsk_map(lfsrBit, amp_q), 16'h0000} : '0;
    assign busy          = (state_q == PULSE) || (state_q == GAP);
    assign done          = (state_q == DONE);
    assign pulse_cnt     = pulseCnt_q;

endmodule

// File: tb/tb_pulse_pn_tx.sv
// Bench for pulse_pn_tx: a burst-level reference model queues every expected
// beat; one monitor compares each handshake, stall stability and done timing.
module tb_pulse_pn_tx;

    localparam int LW = 3;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic [15:0]   seqLen;
    logic [CW-1:0] numPulses;
    logic [CW-1:0] gapLen;
    logic [15:0]   amplitude;
    logic [LW-1:0] poly;
    logic [LW-1:0] seed;
    logic          busy;
    logic [CW-1:0] pulseCnt;
    logic          done;

    pulse_pn_tx_if axis();

    pulse_pn_tx #(.LFSR_W(LW), .CNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .seq_len    (seqLen),
        .num_pulses (numPulses),
        .gap_len    (gapLen),
        .amplitude  (amplitude),
        .lfsr_poly  (poly),
        .lfsr_seed  (seed),
        .axis       (axis),
        .busy       (busy),
        .pulse_cnt  (pulseCnt),
        .done       (done)
    );

    always #5 clk = ~clk;

    int assertions = 0;
    int failures   = 0;
    int cyc        = 0;
    logic randReady = 1'b0;

    logic [32:0] expBeats[$];
    int          beatLog[$];
    logic [31:0] dataLog[$];
    int          doneLog[$];
    logic        stallValid = 1'b0;
    logic [31:0] stallData;
    logic        stallLast;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        assertions++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Sample of beat k of a pulse, straight from the chip rules: LSB is the
    // chip, feedback parity of (state & poly) enters at the top.
    function automatic logic [31:0] pnSample(input int sd, input int pl, input logic [15:0] amp, input int k);
        int s;
        int fb;
        logic [15:0] neg;
        s = sd & ((1 << LW) - 1);
        if (s == 0) s = 1;
        for (int i = 0; i < k; i++) begin
            fb = $countones(s & pl) & 1;
            s  = (s >> 1) | (fb << (LW - 1));
        end
        neg = 16'h0000 - amp;
        return (s & 1) ? {amp, 16'h0000} : {neg, 16'h0000};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clearLogs;
        beatLog.delete();
        dataLog.delete();
        doneLog.delete();
    endtask

    // Configure, pulse start for one cycle, and queue the beats of `emit` pulses.
    task automatic applyStimulus(input int sl, input int np, input int gl, input logic [15:0] amp,
                                 input int pl, input int sd, input int emit, output int startCyc);
        seqLen    = 16'(sl);
        numPulses = CW'(np);
        gapLen    = CW'(gl);
        amplitude = amp;
        poly      = LW'(pl);
        seed      = LW'(sd);
        for (int p = 0; p < emit; p++)
            for (int k = 0; k < sl; k++)
                expBeats.push_back({(k == sl - 1), pnSample(sd, pl, amp, k)});
        start    = 1'b1;
        startCyc = cyc;
        tick();
        start    = 1'b0;
    endtask

    task automatic waitDone(input int maxc);
        int d0 = doneLog.size();
        int n  = 0;
        while (doneLog.size() == d0 && n < maxc) begin
            tick();
            n++;
        end
        checkOutput("done within budget", 64'(doneLog.size() > d0), 1);
    endtask

    task automatic waitBeats(input int nb, input int maxc);
        int n = 0;
        while (beatLog.size() < nb && n < maxc) begin
            tick();
            n++;
        end
        checkOutput("beats within budget", 64'(beatLog.size() >= nb), 1);
    endtask

    // Drive a start that must be rejected and verify nothing happens.
    task automatic pokeStart(input string name, input int sl, input int np, input logic ab);
        clearLogs();
        seqLen    = 16'(sl);
        numPulses = CW'(np);
        gapLen    = CW'(2);
        start     = 1'b1;
        abort     = ab;
        tick();
        start     = 1'b0;
        abort     = 1'b0;
        repeat (8) tick();
        checkOutput({name, " no beats"}, 64'(beatLog.size()), 0);
        checkOutput({name, " no done"}, 64'(doneLog.size()), 0);
        checkOutput({name, " busy"}, 64'(busy), 0);
    endtask

    // Monitor: every handshake against the model, stalls must hold, done logged.
    initial begin
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (reset) begin
                stallValid = 1'b0;
            end else begin
                if (axis.o_tvalid) begin
                    checkOutput("busy while valid", 64'(busy), 1);
                    if (stallValid) begin
                        checkOutput("stall tdata", 64'(axis.o_tdata), 64'(stallData));
                        checkOutput("stall tlast", 64'(axis.o_tlast), 64'(stallLast));
                    end
                    if (axis.o_tready) begin
                        beatLog.push_back(cyc);
                        dataLog.push_back(axis.o_tdata);
                        checkOutput("beat expected", 64'(expBeats.size() != 0), 1);
                        if (expBeats.size() != 0) begin
                            e = expBeats.pop_front();
                            checkOutput("beat tdata", 64'(axis.o_tdata), 64'(e[31:0]));
                            checkOutput("beat tlast", 64'(axis.o_tlast), 64'(e[32]));
                        end
                        stallValid = 1'b0;
                    end else begin
                        stallValid = 1'b1;
                        stallData  = axis.o_tdata;
                        stallLast  = axis.o_tlast;
                    end
                end else begin
                    stallValid = 1'b0;
                end
                if (done) begin
                    doneLog.push_back(cyc);
                    checkOutput("busy at done", 64'(busy), 0);
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (randReady) axis.o_tready = ($urandom_range(0, 1) == 1);
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int sc;
        int ac;
        int sl, np, gl, pl, sd;
        logic [15:0] amp;

        reset = 1'b1; start = 1'b0; abort = 1'b0;
        seqLen = '0; numPulses = '0; gapLen = '0; amplitude = '0; poly = '0; seed = '0;
        axis.o_tready = 1'b1;
        repeat (3) tick();
        checkOutput("reset tvalid", 64'(axis.o_tvalid), 0);
        checkOutput("reset tlast", 64'(axis.o_tlast), 0);
        checkOutput("reset tdata", 64'(axis.o_tdata), 0);
        checkOutput("reset busy", 64'(busy), 0);
        checkOutput("reset done", 64'(done), 0);
        checkOutput("reset pulse_cnt", 64'(pulseCnt), 0);
        reset = 1'b0;
        tick();

        $display("[TB] model pins");
        checkOutput("model pin beat1", 64'(pnSample(1, 3, 16'h4000, 0)), 64'h40000000);
        checkOutput("model pin beat2", 64'(pnSample(1, 3, 16'h4000, 1)), 64'hC0000000);
        checkOutput("model pin beat3", 64'(pnSample(1, 3, 16'h4000, 2)), 64'hC0000000);
        checkOutput("model pin beat4", 64'(pnSample(1, 3, 16'h4000, 3)), 64'h40000000);
        checkOutput("model pin seed0", 64'(pnSample(0, 3, 16'h4000, 1)), 64'hC0000000);

        $display("[TB] basic burst");
        clearLogs();
        applyStimulus(4, 2, 3, 16'h4000, 3, 1, 2, sc);
        waitDone(100);
        checkOutput("basic beat count", 64'(beatLog.size()), 8);
        checkOutput("basic first beat latency", 64'(beatLog[0] - sc), 1);
        checkOutput("basic pulse1 contiguous", 64'(beatLog[3] - beatLog[0]), 3);
        checkOutput("basic gap spacing", 64'(beatLog[4] - beatLog[3]), 4);
        checkOutput("basic pulse2 contiguous", 64'(beatLog[7] - beatLog[4]), 3);
        checkOutput("basic done timing", 64'(doneLog[0] - beatLog[7]), 1);
        checkOutput("basic pulse_cnt", 64'(pulseCnt), 2);
        repeat (4) tick();
        checkOutput("basic done one-shot", 64'(doneLog.size()), 1);
        checkOutput("basic model drained", 64'(expBeats.size()), 0);

        $display("[TB] backpressure");
        clearLogs();
        randReady = 1'b1;
        applyStimulus(4, 2, 3, 16'h4000, 3, 1, 2, sc);
        waitDone(400);
        randReady = 1'b0;
        axis.o_tready = 1'b1;
        checkOutput("bp beat count", 64'(beatLog.size()), 8);
        checkOutput("bp pulse_cnt", 64'(pulseCnt), 2);
        checkOutput("bp model drained", 64'(expBeats.size()), 0);

        $display("[TB] back-to-back");
        clearLogs();
        applyStimulus(4, 3, 0, 16'h4000, 3, 1, 3, sc);
        waitDone(100);
        checkOutput("b2b beat count", 64'(beatLog.size()), 12);
        checkOutput("b2b no bubble", 64'(beatLog[11] - beatLog[0]), 11);
        checkOutput("b2b pulse_cnt", 64'(pulseCnt), 3);

        $display("[TB] abort in pulse");
        clearLogs();
        applyStimulus(4, 5, 3, 16'h4000, 3, 1, 1, sc);
        waitBeats(1, 50);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        waitDone(100);
        repeat (10) tick();
        checkOutput("abort beat count", 64'(beatLog.size()), 4);
        checkOutput("abort done timing", 64'(doneLog[0] - beatLog[3]), 1);
        checkOutput("abort pulse_cnt", 64'(pulseCnt), 1);

        $display("[TB] abort in gap");
        clearLogs();
        applyStimulus(4, 5, 6, 16'h4000, 3, 1, 1, sc);
        waitBeats(4, 50);
        abort = 1'b1;
        ac    = cyc;
        tick();
        abort = 1'b0;
        waitDone(20);
        repeat (10) tick();
        checkOutput("gap abort done timing", 64'(doneLog[0] - ac), 1);
        checkOutput("gap abort beat count", 64'(beatLog.size()), 4);
        checkOutput("gap abort pulse_cnt", 64'(pulseCnt), 1);

        $display("[TB] rejected starts");
        poly = 3'b011; seed = 3'b001; amplitude = 16'h4000;
        pokeStart("seq_len zero", 0, 2, 1'b0);
        pokeStart("num_pulses zero", 4, 0, 1'b0);
        pokeStart("start with abort", 4, 2, 1'b1);

        $display("[TB] start while busy and config snapshot");
        clearLogs();
        applyStimulus(4, 2, 3, 16'h4000, 3, 1, 2, sc);
        waitBeats(2, 50);
        seqLen = 16'd2; numPulses = CW'(1); gapLen = '0;
        amplitude = 16'h1234; poly = 3'b101; seed = 3'b110;
        start = 1'b1;
        tick();
        start = 1'b0;
        waitDone(100);
        checkOutput("busy start beat count", 64'(beatLog.size()), 8);
        checkOutput("busy start gap spacing", 64'(beatLog[4] - beatLog[3]), 4);
        checkOutput("busy start pulse_cnt", 64'(pulseCnt), 2);

        $display("[TB] reset mid-pulse");
        clearLogs();
        applyStimulus(4, 2, 3, 16'h4000, 3, 1, 2, sc);
        waitBeats(6, 50);
        checkOutput("pre-reset pulse_cnt", 64'(pulseCnt), 1);
        reset = 1'b1;
        tick();
        checkOutput("mid reset tvalid", 64'(axis.o_tvalid), 0);
        checkOutput("mid reset busy", 64'(busy), 0);
        checkOutput("mid reset pulse_cnt", 64'(pulseCnt), 0);
        checkOutput("mid reset tdata", 64'(axis.o_tdata), 0);
        expBeats.delete();
        reset = 1'b0;
        tick();
        clearLogs();
        applyStimulus(4, 1, 0, 16'h4000, 3, 1, 1, sc);
        waitDone(50);
        checkOutput("post reset first beat", 64'(dataLog[0]), 64'h40000000);
        checkOutput("post reset first latency", 64'(beatLog[0] - sc), 1);

        $display("[TB] randomized bursts");
        for (int it = 0; it < 10; it++) begin
            sl  = $urandom_range(1, 6);
            np  = $urandom_range(1, 3);
            gl  = $urandom_range(0, 3);
            pl  = $urandom_range(0, 7);
            sd  = $urandom_range(0, 7);
            amp = 16'($urandom);
            clearLogs();
            randReady = 1'b1;
            applyStimulus(sl, np, gl, amp, pl, sd, np, sc);
            waitDone(1000);
            randReady = 1'b0;
            axis.o_tready = 1'b1;
            checkOutput("rand pulse_cnt", 64'(pulseCnt), 64'(np));
            checkOutput("rand beat count", 64'(beatLog.size()), 64'(sl * np));
            checkOutput("rand model drained", 64'(expBeats.size()), 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
